// File: rtl/div_pkg.sv
// Purpose: shared definitions for the clock-divider family (state encoding, width helper).
// Latency: n/a (package only).
// Backpressure: n/a.
package div_pkg;

   // State encodings, shared with other divider-family blocks that decode state.
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_LOCKED  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = S_IDLE,
      ST_MEASURE = S_MEASURE,
      ST_LOCKED  = S_LOCKED
   } div_state_t;

   // The period counter must hold the timeout value 2*K.
   function automatic int div_cw(input int k);
      return $clog2(2 * k) + 1;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Purpose: two-flop synchronizer for an asynchronous level, plus a rising-edge pulse.
// Latency: o_rise is high in the cycle after the second sync flop captures the high level.
// Backpressure: none; one pulse per sampled 0->1 transition.
// Ports: i_clk (sampling clock), i_rst (sync active-high), i_async (async level),
//        o_rise (one-cycle pulse in the i_clk domain).
module sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta   <= 1'b0;
         r_sync   <= 1'b0;
         r_sync_d <= 1'b0;
      end else begin
         r_meta   <= i_async;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/div_clk_meter.sv
// Purpose: measures the period of a divided clock in i_clk_in cycles, tracks lock and errors.
// Latency: period/period_vld registered 3 i_clk_in edges after i_div_in rises (sync + edge).
// Backpressure: none; o_period_vld is a one-cycle pulse per accepted rise.
// Ports: i_clk_in (reference clock), i_rst_ (sync active-high reset), i_div_in (async divided
//        clock), i_err_clr (pulse, clears sticky err), o_period (last period), o_period_vld
//        (update pulse), o_locked (K +/- TOL for LOCK_CNT periods), o_err (sticky fault).
module div_clk_meter
   import div_pkg::*;
#(
   parameter  int K        = 16,
   parameter  int TOL      = 1,
   parameter  int LOCK_CNT = 4,
   localparam int CW       = div_cw(K)
) (
   input  logic          i_clk_in,
   input  logic          i_rst_,
   input  logic          i_div_in,
   input  logic          i_err_clr,
   output logic [CW-1:0] o_period,
   output logic          o_period_vld,
   output logic          o_locked,
   output logic          o_err
);

   localparam int              GW      = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(2 * K);
   localparam logic [CW:0]     K_X     = (CW + 1)'(K);
   localparam logic [CW:0]     TOL_X   = (CW + 1)'(TOL);
   localparam logic [GW-1:0]   LAST_GOOD = GW'(LOCK_CNT - 1);

   div_state_t    r_state, w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [GW-1:0] r_good_cnt, w_good_nxt;
   logic [CW-1:0] r_period, w_period_nxt;
   logic          r_period_vld, w_vld_nxt;
   logic          r_locked, w_locked_nxt;
   logic          r_err, w_err_nxt, w_err_set;

   logic          w_rise;
   logic          w_tmo;
   logic [CW:0]   w_meas_x;
   logic [CW:0]   w_diff;
   logic          w_good;

   sync_edge u_sync_edge (
      .i_clk   (i_clk_in),
      .i_rst   (i_rst_),
      .i_async (i_div_in),
      .o_rise  (w_rise)
   );

   // Compare one bit wider than the counter so |cnt - K| never wraps.
   assign w_meas_x = {1'b0, r_cnt};
   assign w_diff   = (w_meas_x >= K_X) ? (w_meas_x - K_X) : (K_X - w_meas_x);
   assign w_good   = (w_diff <= TOL_X);
   // Saturated counter with no edge this cycle: divided clock considered stalled.
   assign w_tmo    = (r_cnt == CNT_MAX) && !w_rise;

   always_comb begin
      w_state_nxt  = r_state;
      w_good_nxt   = r_good_cnt;
      w_period_nxt = r_period;
      w_vld_nxt    = 1'b0;
      w_locked_nxt = r_locked;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // First edge after reset only starts the counter; that period is partial.
            if (w_rise) w_state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (w_rise) begin
               w_period_nxt = r_cnt;
               w_vld_nxt    = 1'b1;
               if (w_good) begin
                  if (r_good_cnt == LAST_GOOD) begin
                     w_state_nxt  = ST_LOCKED;
                     w_locked_nxt = 1'b1;
                  end
                  w_good_nxt = r_good_cnt + 1'b1;
               end else begin
                  w_good_nxt = '0;
               end
            end else if (w_tmo) begin
               w_good_nxt = '0;
            end
         end
         ST_LOCKED: begin
            if (w_rise) begin
               w_period_nxt = r_cnt;
               w_vld_nxt    = 1'b1;
               if (!w_good) begin
                  w_err_set    = 1'b1;
                  w_locked_nxt = 1'b0;
                  w_good_nxt   = '0;
                  w_state_nxt  = ST_MEASURE;
               end
            end else if (w_tmo) begin
               w_err_set    = 1'b1;
               w_locked_nxt = 1'b0;
               w_good_nxt   = '0;
               w_state_nxt  = ST_MEASURE;
            end
         end
         default: begin
            w_state_nxt  = ST_IDLE;
            w_locked_nxt = 1'b0;
            w_good_nxt   = '0;
         end
      endcase
      // A new fault in the same cycle as a clear request keeps err set.
      w_err_nxt = w_err_set ? 1'b1 : (i_err_clr ? 1'b0 : r_err);
   end

   always_ff @(posedge i_clk_in) begin
      if (i_rst_) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_good_cnt   <= '0;
         r_period     <= '0;
         r_period_vld <= 1'b0;
         r_locked     <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_good_cnt   <= w_good_nxt;
         r_period     <= w_period_nxt;
         r_period_vld <= w_vld_nxt;
         r_locked     <= w_locked_nxt;
         r_err        <= w_err_nxt;
         if (w_rise) begin
            r_cnt <= CW'(1);
         end else if (r_state != ST_IDLE && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_period     = r_period;
   assign o_period_vld = r_period_vld;
   assign o_locked     = r_locked;
   assign o_err        = r_err;

endmodule
